// File: rtl/nibble_serializer_pkg.sv
// nibble_ser_pkg: shared state type, default width and start/end bit index helpers
package nibble_ser_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_DATA_W = 4;
  function automatic int start_idx(input bit msb_first, input int dw);
    return msb_first ? dw - 1 : 0;
  endfunction
  function automatic int end_idx(input bit msb_first, input int dw);
    return msb_first ? 0 : dw - 1;
  endfunction
endpackage

// File: rtl/nibble_serializer_if.sv
// nibble_serializer_if: word-in / bit-out handshake bundle with status
interface nibble_serializer_if #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = $clog2(DATA_W)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_number;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_bit;
  logic [DATA_W-1:0] ser_number;
  logic [SEL_W-1:0]  ser_sel;
  logic              ser_last;
  logic              busy;
  modport master (
    output in_valid, in_number, ser_ready,
    input  in_ready, ser_valid, ser_bit, ser_number, ser_sel, ser_last, busy
  );
  modport slave (
    input  in_valid, in_number, ser_ready,
    output in_ready, ser_valid, ser_bit, ser_number, ser_sel, ser_last, busy
  );
endinterface

// File: rtl/nibble_serializer_bit_select.sv
// ser_bit_select: combinational DATA_W:1 bit pick of a word by index
module ser_bit_select import nibble_ser_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] i_number,
  input  logic [SEL_W-1:0]  i_sel,
  output logic              o_bit
);
  assign o_bit = i_number[i_sel];
endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer: parallel word to serial bits with a one-word pending buffer
module nibble_serializer import nibble_ser_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SEL_W     = $clog2(DATA_W),
  parameter bit MSB_FIRST = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  nibble_serializer_if.slave bus
);
  localparam logic [SEL_W-1:0] START = SEL_W'(start_idx(MSB_FIRST, DATA_W));
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(end_idx(MSB_FIRST, DATA_W));
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_active, w_active_nxt;
  logic [DATA_W-1:0] r_pending, w_pending_nxt;
  logic              r_pend_full, w_pend_full_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic              w_valid, w_in_xfer, w_beat, w_last, w_end_beat, w_bypass, w_sel_bit;
  assign w_valid    = r_state == SHIFT;
  assign w_in_xfer  = bus.in_valid && !r_pend_full;
  assign w_last     = r_sel == LAST;
  assign w_beat     = w_valid && bus.ser_ready;
  assign w_end_beat = w_beat && w_last;
  assign w_bypass   = w_end_beat && !r_pend_full && w_in_xfer;
  ser_bit_select #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_sel (
    .i_number (r_active),
    .i_sel    (r_sel),
    .o_bit    (w_sel_bit)
  );
  // next state: load on idle, step the index per beat, chain words at the last beat
  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_pending_nxt   = r_pending;
    w_pend_full_nxt = r_pend_full;
    w_sel_nxt       = r_sel;
    if (!w_valid) begin
      if (w_in_xfer) begin
        w_active_nxt = bus.in_number;
        w_sel_nxt    = START;
        w_state_nxt  = SHIFT;
      end
    end else begin
      if (w_beat && !w_last) w_sel_nxt = MSB_FIRST ? r_sel - SEL_W'(1) : r_sel + SEL_W'(1);
      if (w_end_beat) begin
        w_sel_nxt = START;
        if (r_pend_full) begin
          w_active_nxt    = r_pending;
          w_pend_full_nxt = 1'b0;
        end else if (w_in_xfer) w_active_nxt = bus.in_number;
        else w_state_nxt = IDLE;
      end
      if (w_in_xfer && !w_bypass) begin
        w_pending_nxt   = bus.in_number;
        w_pend_full_nxt = 1'b1;
      end
    end
  end
  // state registers, cleared asynchronously so a reset mid-word discards everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_sel       <= START;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_sel       <= w_sel_nxt;
    end
  end
  assign bus.in_ready   = !r_pend_full;
  assign bus.ser_valid  = w_valid;
  assign bus.ser_number = r_active;
  assign bus.ser_sel    = r_sel;
  assign bus.ser_last   = w_valid && w_last;
  assign bus.ser_bit    = w_valid && w_sel_bit;
  assign bus.busy       = w_valid || r_pend_full;
endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: LSB-first and MSB-first instances against a word-queue reference model
module tb_nibble_serializer;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic ser_ready = 1'b0;
  logic [DW-1:0] in_number = '0;
  logic [DW-1:0] q[$];
  int k = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] cap0, cap1;
  int ncap = 0;
  nibble_serializer_if #(.DATA_W(DW)) bus0 ();
  nibble_serializer_if #(.DATA_W(DW)) bus1 ();
  assign bus0.in_valid  = in_valid;
  assign bus0.in_number = in_number;
  assign bus0.ser_ready = ser_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_number = in_number;
  assign bus1.ser_ready = ser_ready;
  nibble_serializer #(.DATA_W(DW), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  nibble_serializer #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic check_outputs();
    logic [DW-1:0] w;
    chk("in_ready0", int'(bus0.in_ready), int'(q.size() < 2));
    chk("in_ready1", int'(bus1.in_ready), int'(q.size() < 2));
    chk("busy0", int'(bus0.busy), int'(q.size() > 0));
    chk("busy1", int'(bus1.busy), int'(q.size() > 0));
    chk("valid0", int'(bus0.ser_valid), int'(q.size() > 0));
    chk("valid1", int'(bus1.ser_valid), int'(q.size() > 0));
    if (q.size() > 0) begin
      w = q[0];
      chk("sel0", int'(bus0.ser_sel), k);
      chk("sel1", int'(bus1.ser_sel), DW - 1 - k);
      chk("number0", int'(bus0.ser_number), int'(w));
      chk("number1", int'(bus1.ser_number), int'(w));
      chk("bit0", int'(bus0.ser_bit), int'(w[k]));
      chk("bit1", int'(bus1.ser_bit), int'(w[DW-1-k]));
      chk("last0", int'(bus0.ser_last), int'(k == DW - 1));
      chk("last1", int'(bus1.ser_last), int'(k == DW - 1));
    end else begin
      chk("idle_last0", int'(bus0.ser_last), 0);
      chk("idle_last1", int'(bus1.ser_last), 0);
      chk("idle_bit0", int'(bus0.ser_bit), 0);
      chk("idle_bit1", int'(bus1.ser_bit), 0);
    end
  endtask
  task automatic step(input logic v, input logic [DW-1:0] n, input logic r);
    logic xfer, beat;
    in_valid  = v;
    in_number = n;
    ser_ready = r;
    xfer = v && q.size() < 2;
    beat = q.size() > 0 && r;
    if (bus0.ser_valid && r && ncap < 32) begin
      cap0[ncap] = bus0.ser_bit;
      cap1[ncap] = bus1.ser_bit;
      ncap++;
    end
    @(posedge clk);
    if (beat) begin
      k++;
      if (k == DW) begin
        void'(q.pop_front());
        k = 0;
      end
    end
    if (xfer) q.push_back(n);
    @(negedge clk);
    check_outputs();
  endtask
  task automatic clear_cap();
    cap0 = '0;
    cap1 = '0;
    ncap = 0;
  endtask
  task automatic do_reset();
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    rst_n     = 1'b0;
    q.delete();
    k = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid0", int'(bus0.ser_valid), 0);
    chk("rst_in_ready0", int'(bus0.in_ready), 1);
    chk("rst_busy0", int'(bus0.busy), 0);
    chk("rst_sel0", int'(bus0.ser_sel), 0);
    chk("rst_sel1", int'(bus1.ser_sel), DW - 1);
    chk("rst_number0", int'(bus0.ser_number), 0);
    chk("rst_bit0", int'(bus0.ser_bit), 0);
    chk("rst_last0", int'(bus0.ser_last), 0);
  endtask
  initial begin
    int accepted, cycles;
    do_reset();
    repeat (2) step(1'b0, 4'h0, 1'b1);
    clear_cap();
    step(1'b1, 4'b1011, 1'b1);
    repeat (5) step(1'b0, 4'h0, 1'b1);
    chk("seq_1011_lsb", int'(cap0[3:0]), int'(4'b1011));
    chk("seq_1011_msb", int'(cap1[3:0]), int'(4'b1101));
    chk("seq_1011_beats", ncap, 4);
    clear_cap();
    step(1'b1, 4'b0110, 1'b1);
    step(1'b1, 4'b1001, 1'b1);
    repeat (8) step(1'b0, 4'h0, 1'b1);
    chk("b2b_beats", ncap, 8);
    chk("b2b_seq", int'(cap0[7:0]), int'(8'b1001_0110));
    clear_cap();
    step(1'b1, 4'b1100, 1'b1);
    foreach (cap0[i]) if (i < 10) step(1'b0, 4'h0, (i % 3) == 0);
    repeat (3) step(1'b0, 4'h0, 1'b1);
    chk("bp_beats", ncap, 4);
    chk("bp_seq", int'(cap0[3:0]), int'(4'b1100));
    clear_cap();
    step(1'b1, 4'b1000, 1'b1);
    repeat (5) step(1'b0, 4'h0, 1'b1);
    chk("msb_seq", int'(cap1[3:0]), int'(4'b0001));
    chk("lsb_seq", int'(cap0[3:0]), int'(4'b1000));
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b0101, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid0", int'(bus0.ser_valid), 0);
    chk("async_valid1", int'(bus1.ser_valid), 0);
    chk("async_busy0", int'(bus0.busy), 0);
    chk("async_last0", int'(bus0.ser_last), 0);
    chk("async_in_ready0", int'(bus0.in_ready), 1);
    do_reset();
    repeat (6) step(1'b0, 4'h0, 1'b1);
    accepted = 0;
    cycles = 0;
    while (accepted < 100 && cycles < 3000) begin
      logic v;
      v = $urandom_range(0, 9) < 6;
      if (v && q.size() < 2) accepted++;
      step(v, DW'($urandom), 1'($urandom));
      cycles++;
    end
    chk("rand_words", accepted, 100);
    cycles = 0;
    while (q.size() > 0 && cycles < 100) begin
      step(1'b0, 4'h0, 1'b1);
      cycles++;
    end
    chk("drain_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
